// File: rtl/dmux3way16_buf_pkg.sv
// Shared definitions for the 3-way 16-bit write demux: sel encodings,
// channel indices and the sel-to-channel decode used by the top level.
package dmux3way16_buf_pkg;

   localparam logic [1:0] SEL_X0 = 2'b00;
   localparam logic [1:0] SEL_X1 = 2'b01;
   localparam logic [1:0] SEL_Y  = 2'b10;
   localparam logic [1:0] SEL_Z  = 2'b11;

   localparam int unsigned NCH = 3;

   typedef enum logic [1:0] {
      CH_X = 2'd0,
      CH_Y = 2'd1,
      CH_Z = 2'd2
   } chan_e;

   // Same encoding as the 3-input mux: 00 and 01 both select x.
   function automatic chan_e sel_to_chan(input logic [1:0] sel);
      chan_e ch;
      if (sel == SEL_Z) begin
         ch = CH_Z;
      end else if (sel == SEL_Y) begin
         ch = CH_Y;
      end else begin
         ch = CH_X;
      end
      return ch;
   endfunction

endpackage

// File: rtl/dmux3way16_buf_if.sv
// Bus bundle for dmux3way16_buf: one input word stream with valid/ready
// and three output channels x/y/z, each with its own valid/ready.
interface dmux3way16_buf_if #(
   parameter int unsigned WIDTH = 16
);

   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic             in_valid;
   logic             in_ready;

   logic [WIDTH-1:0] x_data;
   logic             x_valid;
   logic             x_ready;

   logic [WIDTH-1:0] y_data;
   logic             y_valid;
   logic             y_ready;

   logic [WIDTH-1:0] z_data;
   logic             z_valid;
   logic             z_ready;

   // Producer of input words and consumer of the three channels.
   modport master (
      output in_data, in_sel, in_valid,
      input  in_ready,
      input  x_data, x_valid, y_data, y_valid, z_data, z_valid,
      output x_ready, y_ready, z_ready
   );

   // The demux itself.
   modport slave (
      input  in_data, in_sel, in_valid,
      output in_ready,
      output x_data, x_valid, y_data, y_valid, z_data, z_valid,
      input  x_ready, y_ready, z_ready
   );

endinterface

// File: rtl/dmux3way16_buf_chan_fifo16.sv
// Per-channel FIFO: DEPTH entries, registered count, combinational head.
// Storage is cleared on reset so dout reads zero until the first push.
module chan_fifo16 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   // Flags come only from the registered count; push/pop are qualified by them.
   always_comb begin
      full    = (cnt == FULL_CNT);
      empty   = (cnt == '0);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      dout    = mem[rd_ptr];
   end

   // Storage write at the write pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH since DEPTH == 2**AW.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy count: simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/dmux3way16_buf.sv
// 3-way 16-bit write demux with a small FIFO per destination channel.
// Top level only decodes in_sel, selects in_ready and fans out the push.
module dmux3way16_buf
   import dmux3way16_buf_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 1
) (
   input logic              clk,
   input logic              reset,
   dmux3way16_buf_if.slave  bus
);

   chan_e            tgt;
   logic [NCH-1:0]   full;
   logic [NCH-1:0]   empty;
   logic [NCH-1:0]   push;
   logic [NCH-1:0]   pop;
   logic [NCH-1:0]   cready;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout [NCH];

   // Decode and push fan-out; in_ready depends only on in_sel and registered full flags.
   always_comb begin
      tgt          = sel_to_chan(bus.in_sel);
      bus.in_ready = ~full[tgt];
      din          = bus.in_data;
      push         = '0;
      push[tgt]    = bus.in_valid & ~full[tgt];
   end

   // Consumer handshakes and channel outputs.
   always_comb begin
      cready      = {bus.z_ready, bus.y_ready, bus.x_ready};
      pop         = cready & ~empty;
      bus.x_valid = ~empty[CH_X];
      bus.y_valid = ~empty[CH_Y];
      bus.z_valid = ~empty[CH_Z];
      bus.x_data  = dout[CH_X];
      bus.y_data  = dout[CH_Y];
      bus.z_data  = dout[CH_Z];
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      chan_fifo16 #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[c]),
         .din   (din),
         .full  (full[c]),
         .pop   (pop[c]),
         .dout  (dout[c]),
         .empty (empty[c])
      );
   end

endmodule
